// File: rtl/dflow_sched_pkg.sv
// dflow_sched_pkg: state encoding and error codes shared by the
// store/replay sequencer and its helper blocks.
package dflow_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CAL = 3'd1,
        ST_STORE    = 3'd2,
        ST_GAP      = 3'd3,
        ST_REPLAY   = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } sched_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CFG  = 2'd1;
    localparam logic [1:0] ERR_CAL  = 2'd2;
    localparam logic [1:0] ERR_WDOG = 2'd3;

endpackage

// File: rtl/dflow_sched_timer.sv
// dflow_sched_timer: loadable down-counter that parks at zero and
// flags it. Load has priority over counting.
module dflow_sched_timer
    import dflow_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    assign zero = (count == '0);

    // Reload on request, otherwise count down while enabled and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/dflow_store_replay_ctrl.sv
// dflow_store_replay_ctrl: walks the store writer through one fill of
// the latched memory window, waits for the last write to drain, then
// runs the replay reader for the programmed number of passes.
// Optional store-stall watchdog: define DFLOW_SCHED_WDOG_EN.
module dflow_store_replay_ctrl
    import dflow_sched_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int LOOP_CNT_WIDTH = 32,
    parameter int GAP_CYCLES     = 16,
    parameter int WDOG_CYCLES    = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cal_done,
    input  logic [MEM_ADDR_WIDTH-1:0] cfg_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0] cfg_addr_high,
    input  logic [LOOP_CNT_WIDTH-1:0] cfg_loop_count,
    input  logic                      cmd_start,
    input  logic                      cmd_stop,
    input  logic                      compelete_store,
    input  logic [MEM_ADDR_WIDTH-1:0] dflow_mem_high,
    input  logic                      replay_pass_done,
    output logic                      wr_sw_rst,
    output logic                      start_store,
    output logic [MEM_ADDR_WIDTH-1:0] dflow_addr_low,
    output logic [MEM_ADDR_WIDTH-1:0] dflow_addr_high,
    output logic                      replay_en,
    output logic [MEM_ADDR_WIDTH-1:0] replay_addr_low,
    output logic [MEM_ADDR_WIDTH-1:0] replay_addr_high,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [2:0]                state,
    output logic [LOOP_CNT_WIDTH-1:0] pass_cnt
);

    // Both timer instances share one width so they can count either interval
    localparam int TMR_MAX = (GAP_CYCLES > WDOG_CYCLES) ? GAP_CYCLES : WDOG_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    sched_state_t              state_q;
    sched_state_t              state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] stored_high;
    logic [LOOP_CNT_WIDTH-1:0] loop_q;
    logic [LOOP_CNT_WIDTH-1:0] pass_inc;
    logic                      cal_wait_q;
    logic                      win_ok;
    logic                      cal_lost;
    logic                      pass_adv;
    logic                      gap_zero;
    logic                      wdog_fire;

    assign state    = state_q;
    assign win_ok   = {1'b0, cfg_addr_high} > ({1'b0, cfg_addr_low} + (MEM_ADDR_WIDTH + 1)'(1));
    assign cal_lost = !cal_done && (state_q inside {ST_STORE, ST_GAP, ST_REPLAY});
    assign pass_inc = (&pass_cnt) ? pass_cnt : pass_cnt + LOOP_CNT_WIDTH'(1);

    dflow_sched_timer #(.WIDTH(TMR_W)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state_q == ST_STORE) && (state_nxt == ST_GAP)),
        .load_val (TMR_W'(GAP_CYCLES - 1)),
        .en       (state_q == ST_GAP),
        .zero     (gap_zero)
    );

`ifdef DFLOW_SCHED_WDOG_EN
    logic [MEM_ADDR_WIDTH-1:0] mem_prev;
    logic                      mem_moved;
    logic                      wdog_zero;

    assign mem_moved = (dflow_mem_high != mem_prev);
    assign wdog_fire = (state_q == ST_STORE) && !mem_moved && wdog_zero;

    // Track the writer pointer so any movement restarts the stall count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_prev <= '0;
        end else begin
            mem_prev <= dflow_mem_high;
        end
    end

    dflow_sched_timer #(.WIDTH(TMR_W)) u_wdog_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (((state_nxt == ST_STORE) && (state_q != ST_STORE)) ||
                   ((state_q == ST_STORE) && mem_moved)),
        .load_val (TMR_W'(WDOG_CYCLES - 1)),
        .en       (state_q == ST_STORE),
        .zero     (wdog_zero)
    );
`else
    assign wdog_fire = 1'b0;
`endif

    // Next-state decision: stop beats everything, then calibration loss
    always_comb begin
        state_nxt = state_q;
        pass_adv  = 1'b0;
        if (cmd_stop) begin
            state_nxt = ST_IDLE;
        end else if (cal_lost) begin
            state_nxt = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (cmd_start && win_ok) state_nxt = ST_WAIT_CAL;
                end
                ST_WAIT_CAL: begin
                    if (cal_done && cal_wait_q) state_nxt = ST_STORE;
                end
                ST_STORE: begin
                    if (compelete_store)  state_nxt = ST_GAP;
                    else if (wdog_fire)   state_nxt = ST_ERR;
                end
                ST_GAP: begin
                    if (gap_zero) state_nxt = ST_REPLAY;
                end
                ST_REPLAY: begin
                    if (replay_pass_done) begin
                        pass_adv = 1'b1;
                        if ((loop_q != '0) && (pass_inc == loop_q)) state_nxt = ST_DONE;
                    end
                end
                ST_ERR:  state_nxt = ST_ERR;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, registered outputs decoded from next state, and datapath captures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cal_wait_q       <= 1'b0;
            wr_sw_rst        <= 1'b0;
            start_store      <= 1'b0;
            replay_en        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            err_code         <= ERR_NONE;
            dflow_addr_low   <= '0;
            dflow_addr_high  <= '0;
            replay_addr_low  <= '0;
            replay_addr_high <= '0;
            loop_q           <= '0;
            stored_high      <= '0;
            pass_cnt         <= '0;
        end else begin
            state_q     <= state_nxt;
            cal_wait_q  <= (state_q == ST_WAIT_CAL) && (state_nxt == ST_WAIT_CAL);
            wr_sw_rst   <= (state_nxt == ST_WAIT_CAL) && (state_q != ST_WAIT_CAL);
            start_store <= (state_nxt == ST_STORE);
            replay_en   <= (state_nxt == ST_REPLAY);
            busy        <= state_nxt inside {ST_WAIT_CAL, ST_STORE, ST_GAP, ST_REPLAY};
            done        <= (state_nxt == ST_DONE);

            if (cmd_stop) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end else if (cal_lost) begin
                err      <= 1'b1;
                err_code <= ERR_CAL;
            end else if ((state_q == ST_STORE) && (state_nxt == ST_ERR)) begin
                err      <= 1'b1;
                err_code <= ERR_WDOG;
            end else if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && cmd_start) begin
                if (win_ok) begin
                    dflow_addr_low  <= cfg_addr_low;
                    dflow_addr_high <= cfg_addr_high;
                    loop_q          <= cfg_loop_count;
                    pass_cnt        <= '0;
                    err             <= 1'b0;
                    err_code        <= ERR_NONE;
                end else begin
                    err      <= 1'b1;
                    err_code <= ERR_CFG;
                end
            end

            if ((state_q == ST_STORE) && (state_nxt == ST_GAP)) begin
                stored_high <= dflow_mem_high;
            end

            if ((state_q == ST_GAP) && (state_nxt == ST_REPLAY)) begin
                replay_addr_low  <= dflow_addr_low;
                replay_addr_high <= stored_high + MEM_ADDR_WIDTH'(1);
            end

            if (pass_adv) begin
                pass_cnt <= pass_inc;
            end
        end
    end

endmodule

// File: tb/tb_dflow_store_replay_ctrl.sv
// tb_dflow_store_replay_ctrl: scoreboard bench for the store/replay
// sequencer with emulated writer and reader. Define DFLOW_SCHED_WDOG_EN
// for both bench and design to cover the store watchdog.
module tb_dflow_store_replay_ctrl;

    localparam int AW   = 19;
    localparam int LW   = 32;
    localparam int GAP  = 16;
    localparam int WDOG = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cal_done = 1'b0;
    logic [AW-1:0] cfg_addr_low = '0;
    logic [AW-1:0] cfg_addr_high = '0;
    logic [LW-1:0] cfg_loop_count = '0;
    logic          cmd_start = 1'b0;
    logic          cmd_stop = 1'b0;
    logic          compelete_store = 1'b0;
    logic [AW-1:0] dflow_mem_high = '0;
    logic          replay_pass_done = 1'b0;

    logic          wr_sw_rst;
    logic          start_store;
    logic [AW-1:0] dflow_addr_low;
    logic [AW-1:0] dflow_addr_high;
    logic          replay_en;
    logic [AW-1:0] replay_addr_low;
    logic [AW-1:0] replay_addr_high;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [2:0]    state;
    logic [LW-1:0] pass_cnt;

    always #5 clk = ~clk;

    dflow_store_replay_ctrl #(
        .MEM_ADDR_WIDTH (AW),
        .LOOP_CNT_WIDTH (LW),
        .GAP_CYCLES     (GAP),
        .WDOG_CYCLES    (WDOG)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cal_done         (cal_done),
        .cfg_addr_low     (cfg_addr_low),
        .cfg_addr_high    (cfg_addr_high),
        .cfg_loop_count   (cfg_loop_count),
        .cmd_start        (cmd_start),
        .cmd_stop         (cmd_stop),
        .compelete_store  (compelete_store),
        .dflow_mem_high   (dflow_mem_high),
        .replay_pass_done (replay_pass_done),
        .wr_sw_rst        (wr_sw_rst),
        .start_store      (start_store),
        .dflow_addr_low   (dflow_addr_low),
        .dflow_addr_high  (dflow_addr_high),
        .replay_en        (replay_en),
        .replay_addr_low  (replay_addr_low),
        .replay_addr_high (replay_addr_high),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .err_code         (err_code),
        .state            (state),
        .pass_cnt         (pass_cnt)
    );

    typedef struct {
        bit            is_err;
        logic [1:0]    code;
        logic [2:0]    st;
        logic [LW-1:0] passes;
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic done_prev = 1'b0;
    logic err_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stopJob();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        checkOutput("stop_idle", 64'({state, busy, err, replay_en, start_store}), 64'(0));
    endtask

    // Monitor: every rising done or err is a completed job; pop and compare
    always @(negedge clk) begin
        exp_t e;
        if ((done && !done_prev) || (err && !err_prev)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_event", 64'({err, done}), 64'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("ev_kind", 64'(err), 64'(e.is_err));
                checkOutput("ev_state", 64'(state), 64'(e.st));
                if (e.is_err) begin
                    checkOutput("ev_err_code", 64'(err_code), 64'(e.code));
                end else begin
                    checkOutput("ev_pass_cnt", 64'(pass_cnt), 64'(e.passes));
                    checkOutput("ev_replay_lo", 64'(replay_addr_low), 64'(e.lo));
                    checkOutput("ev_replay_hi", 64'(replay_addr_high), 64'(e.hi));
                end
            end
        end
        done_prev = done;
        err_prev  = err;
    end

    // mode 0: normal run, 1: calibration drop in STORE, 2: reset in REPLAY, 3: frozen writer
    task automatic applyStimulus(input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                                 input logic [LW-1:0] loop, input int mode);
        exp_t e;
        int   n;
        int   npass;
        bit   ok;
        ok = (int'(hi) > int'(lo) + 1);
        cfg_addr_low   = lo;
        cfg_addr_high  = hi;
        cfg_loop_count = loop;
        dflow_mem_high = lo;
        e.is_err = !ok;
        e.code   = 2'd1;
        e.st     = ok ? 3'd5 : 3'd0;
        e.passes = loop;
        e.lo     = lo;
        e.hi     = hi;
        if (!ok || (mode == 0 && loop != 0)) exp_q.push_back(e);

        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        cfg_addr_low   = AW'($urandom);
        cfg_addr_high  = AW'($urandom);
        cfg_loop_count = LW'($urandom_range(1, 9));

        if (!ok) begin
            checkOutput("badcfg_state", 64'(state), 64'(0));
            checkOutput("badcfg_enables", 64'({wr_sw_rst, start_store, replay_en, busy}), 64'(0));
            stopJob();
            return;
        end

        checkOutput("start_state", 64'(state), 64'(1));
        checkOutput("start_sw_rst", 64'(wr_sw_rst), 64'(1));
        tick();
        checkOutput("sw_rst_once", 64'(wr_sw_rst), 64'(0));
        n = 0;
        while (!start_store && n < 20) begin
            tick();
            n++;
        end
        checkOutput("cal_wait_cycles", 64'(n), 64'(1));
        checkOutput("writer_lo", 64'(dflow_addr_low), 64'(lo));
        checkOutput("writer_hi", 64'(dflow_addr_high), 64'(hi));

        if (mode == 3) begin
`ifdef DFLOW_SCHED_WDOG_EN
            e.is_err = 1'b1;
            e.code   = 2'd3;
            e.st     = 3'd6;
            exp_q.push_back(e);
            n = 0;
            while (state != 3'd6 && n < 200) begin
                tick();
                n++;
            end
            checkOutput("wdog_cycles", 64'(n), 64'(WDOG));
            checkOutput("wdog_store_off", 64'(start_store), 64'(0));
`else
            repeat (1000) tick();
            checkOutput("nowdog_state", 64'(state), 64'(2));
            checkOutput("nowdog_store", 64'({start_store, err}), 64'(2'b10));
`endif
            stopJob();
            return;
        end

        for (int a = int'(lo); a < int'(hi); a++) begin
            dflow_mem_high = AW'(a);
            if (mode == 1 && a == int'(lo) + 4) begin
                cal_done = 1'b0;
                e.is_err = 1'b1;
                e.code   = 2'd2;
                e.st     = 3'd6;
                exp_q.push_back(e);
                tick();
                checkOutput("cal_lost_store_off", 64'(start_store), 64'(0));
                checkOutput("cal_lost_state", 64'(state), 64'(6));
                cal_done  = 1'b1;
                cmd_start = 1'b1;
                tick();
                cmd_start = 1'b0;
                repeat (3) tick();
                checkOutput("err_sticky", 64'({err, err_code, state}), 64'({1'b1, 2'd2, 3'd6}));
                stopJob();
                return;
            end
            compelete_store = (a == int'(hi) - 1);
            tick();
        end
        compelete_store = 1'b0;
        checkOutput("store_done_off", 64'(start_store), 64'(0));
        checkOutput("gap_state", 64'(state), 64'(3));
        n = 0;
        while (!replay_en && n < 100) begin
            tick();
            n++;
        end
        checkOutput("gap_cycles", 64'(n), 64'(GAP));
        checkOutput("replay_lo", 64'(replay_addr_low), 64'(lo));
        checkOutput("replay_hi", 64'(replay_addr_high), 64'(hi));

        if (mode == 2) begin
            replay_pass_done = 1'b1;
            tick();
            replay_pass_done = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            checkOutput("rst_async_flags", 64'({start_store, replay_en, busy, done, err, wr_sw_rst}), 64'(0));
            checkOutput("rst_async_state", 64'(state), 64'(0));
            checkOutput("rst_async_data", 64'({pass_cnt, replay_addr_high}), 64'(0));
            #2 rst_n = 1'b1;
            tick();
            checkOutput("post_rst_state", 64'(state), 64'(0));
            return;
        end

        npass = (loop == '0) ? 100 : int'(loop);
        for (int p = 1; p <= npass; p++) begin
            repeat ($urandom_range(0, 3)) tick();
            replay_pass_done = 1'b1;
            tick();
            replay_pass_done = 1'b0;
            if (loop != '0 && p < npass) begin
                checkOutput("mid_pass", 64'({state, pass_cnt}), 64'({3'd4, LW'(p)}));
            end
        end

        if (loop == '0) begin
            checkOutput("forever_pass_cnt", 64'(pass_cnt), 64'(100));
            checkOutput("forever_state", 64'(state), 64'(4));
            cmd_stop = 1'b1;
            tick();
            cmd_stop = 1'b0;
            checkOutput("forever_stop", 64'({state, replay_en}), 64'(0));
            checkOutput("forever_hold_cnt", 64'(pass_cnt), 64'(100));
        end else begin
            checkOutput("final_flags", 64'({done, replay_en, busy}), 64'(3'b100));
        end
    endtask

    initial begin
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        int            span;
        rst_n    = 1'b0;
        cal_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flags", 64'({wr_sw_rst, start_store, replay_en, busy, done, err, err_code}), 64'(0));
        checkOutput("reset_state", 64'(state), 64'(0));
        checkOutput("reset_data", 64'({pass_cnt, dflow_addr_low, dflow_addr_high}), 64'(0));
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", 64'(state), 64'(0));

        applyStimulus(19'h100, 19'h110, 32'd3, 0);
        stopJob();
        applyStimulus(19'h20, 19'h21, 32'd5, 0);
        applyStimulus(19'h200, 19'h208, 32'd0, 0);
        applyStimulus(19'h40, 19'h60, 32'd2, 1);
        applyStimulus(19'h300, 19'h310, 32'd1, 3);
        applyStimulus(19'h400, 19'h405, 32'd4, 2);

        for (int i = 0; i < 12; i++) begin
            span = $urandom_range(0, 24);
            lo   = AW'($urandom_range(0, 1000));
            hi   = lo + AW'(span);
            if (span < 2 || $urandom_range(0, 1) == 1) stopJob();
            applyStimulus(lo, hi, LW'($urandom_range(1, 4)), 0);
        end

        repeat (2) tick();
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
